mul_share_ctrl: RTL and testbench

- Shares one combinational 32x32 multiplier (the `mul` unit: MULTU/MULT, 64-bit HI/LO) between NUM_REQ requesters, e.g. pipeline lanes or mesh compare nodes.
- Round-robin arbitration and a valid/ready handshake on each request port.
- A single registered result slot with backpressure, so the multiplier's long combinational path ends in a flop.
- Sits between the requesters and the shared `mul` instance.

---
 rtl/mul_share_ctrl_pkg.sv | 12 +
 rtl/mul_share_ctrl_if.sv | 33 +++
 rtl/mul_share_ctrl_mul.sv | 28 ++
 rtl/mul_share_ctrl_rr_arbiter.sv | 36 +++
 rtl/mul_share_ctrl.sv | 84 ++++++++
 tb/tb_mul_share_ctrl.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// mul_share_defs: shared constants for the shared-multiplier controller.
//   OP_MULTU / OP_MULT : per-request operation encoding
//   DEF_*              : default geometry
//   BUSY_MAX           : saturation value of the stall counter
package mul_share_defs;
  localparam logic        OP_MULTU    = 1'b0;
  localparam logic        OP_MULT     = 1'b1;
  localparam int          DEF_WIDTH   = 32;
  localparam int          DEF_NUM_REQ = 4;
  localparam int          DEF_ID_W    = 2;
  localparam logic [15:0] BUSY_MAX    = 16'hFFFF;
endpackage

// File: rtl/mul_share_ctrl_if.sv
// mul_share_ctrl_if: request/response bus of the shared multiplier.
//   req_*   : per-requester valid/ready handshake, operands are packed
//             [NUM_REQ][WIDTH] (slice i == bits [i*WIDTH +: WIDTH])
//   resp_*  : single result slot, valid/ready handshake
//   busy_cnt: saturating count of stalled result cycles
//   slave   : controller view, master: requesters + consumer view
interface mul_share_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_opa;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_opb;
  logic [NUM_REQ-1:0]            req_op;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic [WIDTH-1:0]              resp_hi;
  logic [WIDTH-1:0]              resp_lo;
  logic [15:0]                   busy_cnt;

  modport slave (
    input  req_valid, req_opa, req_opb, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_hi, resp_lo, busy_cnt
  );

  modport master (
    output req_valid, req_opa, req_opb, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_hi, resp_lo, busy_cnt
  );
endinterface

// File: rtl/mul_share_ctrl_mul.sv
// mul: combinational WIDTH x WIDTH multiplier, MULTU / MULT.
//   i_a, i_b : operands
//   i_op     : 0 = unsigned, 1 = signed
//   o_hi/o_lo: upper / lower halves of the 2*WIDTH product
module mul
  import mul_share_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_op,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic             w_sa, w_sb;
  logic [2*WIDTH-1:0] w_ea, w_eb, w_p;

  // Extending straight to 2*WIDTH gives the low 2*WIDTH bits of the
  // (WIDTH+1)x(WIDTH+1) signed product with a plain modular multiply.
  assign w_sa = (i_op == OP_MULT) & i_a[WIDTH-1];
  assign w_sb = (i_op == OP_MULT) & i_b[WIDTH-1];
  assign w_ea = {{WIDTH{w_sa}}, i_a};
  assign w_eb = {{WIDTH{w_sb}}, i_b};
  assign w_p  = w_ea * w_eb;
  assign o_hi = w_p[2*WIDTH-1:WIDTH];
  assign o_lo = w_p[WIDTH-1:0];
endmodule

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req    : request vector
//   i_ptr    : highest-priority index this cycle
//   i_en     : grant enable (all grants forced low when 0)
//   o_gnt    : one-hot grant, o_gnt_id: its binary index, o_any: a grant exists
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_any
);
  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % N;
  endfunction

  // Scan ptr, ptr+1, ... modulo N; the first hit wins.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N; k++) begin
        if (!o_any && i_req[wrap_idx(int'(i_ptr), k)]) begin
          o_gnt[wrap_idx(int'(i_ptr), k)] = 1'b1;
          o_gnt_id = IW'(wrap_idx(int'(i_ptr), k));
          o_any    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one combinational multiplier between NUM_REQ
// requesters with round-robin arbitration and a single registered
// result slot with backpressure.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mul_share_ctrl_if.slave (requests, result slot, busy_cnt)
module mul_share_ctrl
  import mul_share_defs::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic              clk,
  input  logic              reset,
  mul_share_ctrl_if.slave   bus
);
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_xfer;
  logic               w_slot_free;
  logic [WIDTH-1:0]   w_opa, w_opb, w_hi, w_lo;
  logic               w_op;

  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [WIDTH-1:0]   r_resp_hi, r_resp_lo;
  logic [15:0]        r_busy_cnt;
  logic [ID_W-1:0]    r_rr_ptr;

  assign w_slot_free = ~r_resp_valid | bus.resp_ready;

  // Grants are suppressed during reset so nothing is accepted and dropped.
  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .i_en     (w_slot_free & ~reset),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_xfer)
  );

  assign w_opa = bus.req_opa[w_gnt_id];
  assign w_opb = bus.req_opb[w_gnt_id];
  assign w_op  = bus.req_op[w_gnt_id];

  mul #(.WIDTH(WIDTH)) u_mul (
    .i_a  (w_opa),
    .i_b  (w_opb),
    .i_op (w_op),
    .o_hi (w_hi),
    .o_lo (w_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_hi    <= '0;
      r_resp_lo    <= '0;
      r_busy_cnt   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      // A grant implies the slot is free, so loading covers drain+reload.
      if (w_xfer) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= w_gnt_id;
        r_resp_hi    <= w_hi;
        r_resp_lo    <= w_lo;
        r_rr_ptr     <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
      end else if (bus.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
      if (r_resp_valid && !bus.resp_ready && r_busy_cnt != BUSY_MAX)
        r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign bus.req_ready  = w_gnt;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_hi    = r_resp_hi;
  assign bus.resp_lo    = r_resp_lo;
  assign bus.busy_cnt   = r_busy_cnt;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: the driver pushes the expected
// result whenever it expects a grant; a negedge monitor pops and compares
// on every resp_valid & resp_ready.
module tb_mul_share_ctrl;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  logic [31:0] eh[4];
  logic [31:0] el[4];

  always #5 clk = ~clk;

  mul_share_ctrl_if #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) bus ();

  mul_share_ctrl #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] hi, input logic [31:0] lo);
    bus.req_opa[i] = a;
    bus.req_opb[i] = b;
    bus.req_op[i]  = op;
    eh[i] = hi;
    el[i] = lo;
  endtask

  // One cycle: check the grant vector mid-cycle, log expected results.
  task automatic step(input logic [3:0] eg, input string nm);
    @(negedge clk);
    chk({nm, " grant"}, 64'(bus.req_ready), 64'(eg));
    for (int i = 0; i < 4; i++)
      if (eg[i]) q.push_back('{id: 2'(i), hi: eh[i], lo: el[i]});
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL resp unexpected: got id=%0d hi=%h lo=%h want none",
                 bus.resp_id, bus.resp_hi, bus.resp_lo);
      end else begin
        e = q.pop_front();
        if ({bus.resp_id, bus.resp_hi, bus.resp_lo} !== e) begin
          n_fail++;
          $display("FAIL resp: got id=%0d hi=%h lo=%h want id=%0d hi=%h lo=%h",
                   bus.resp_id, bus.resp_hi, bus.resp_lo, e.id, e.hi, e.lo);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_opa    = '0;
    bus.req_opb    = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin eh[i] = '0; el[i] = '0; end

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 64'(bus.req_ready), 64'h0);
    chk("reset resp_valid", 64'(bus.resp_valid), 64'h0);
    chk("reset busy_cnt", 64'(bus.busy_cnt), 64'h0);
    chk("reset resp_hilo", {bus.resp_hi, bus.resp_lo}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid  = 4'h0;
    bus.resp_ready = 1'b1;

    // Single MULTU on requester 2
    set_op(2, 32'hFFFFFFFF, 32'h2, 1'b0, 32'h1, 32'hFFFFFFFE);
    bus.req_valid = 4'b0100;
    step(4'b0100, "multu r2");
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle1");

    // Signed then unsigned on requester 0 (ptr at 3, then 1)
    set_op(0, 32'hFFFFFFFF, 32'h3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    bus.req_valid = 4'b0001;
    step(4'b0001, "mult r0");
    set_op(0, 32'hFFFFFFFF, 32'h3, 1'b0, 32'h2, 32'hFFFFFFFD);
    step(4'b0001, "multu r0");
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle2");

    // Fairness from ptr=0
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10, 1'b0, 32'h0, 32'((i + 1) * 10));
    bus.req_valid = 4'b1111;
    step(4'b0001, "rr0");
    step(4'b0010, "rr1");
    step(4'b0100, "rr2");
    step(4'b1000, "rr3");
    step(4'b0001, "rr4");
    step(4'b0010, "rr5");
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle3");

    // Sparse: only r3 after r1 served, then pointer wraps to 0
    bus.req_valid = 4'b1000;
    step(4'b1000, "sparse r3");
    bus.req_valid = 4'b1111;
    step(4'b0001, "wrap r0");
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle4");

    // Backpressure
    pulse_reset();
    bus.req_valid = 4'b0010;
    step(4'b0010, "bp load");
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step(4'b0000, "bp stall");
    chk("bp busy_cnt", 64'(bus.busy_cnt), 64'd5);
    chk("bp resp_valid", 64'(bus.resp_valid), 64'h1);
    chk("bp resp held", {30'h0, bus.resp_id, bus.resp_lo}, {30'h0, 2'd1, 32'd20});
    chk("bp resp_hi held", 64'(bus.resp_hi), 64'h0);
    bus.resp_ready = 1'b1;
    step(4'b0010, "bp drain+grant");
    chk("bp valid stays", 64'(bus.resp_valid), 64'h1);
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle5");
    chk("bp busy after", 64'(bus.busy_cnt), 64'd5);

    // Reset mid-stall
    bus.req_valid = 4'b0001;
    step(4'b0001, "rs load");
    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b0;
    step(4'b0000, "rs stall");
    step(4'b0000, "rs stall");
    chk("rs busy pre", 64'(bus.busy_cnt), 64'd7);
    reset = 1'b1;
    q.delete();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rs no grant in reset", 64'(bus.req_ready), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rs resp_valid", 64'(bus.resp_valid), 64'h0);
    chk("rs busy_cnt", 64'(bus.busy_cnt), 64'h0);
    bus.resp_ready = 1'b1;
    step(4'b0001, "rs first grant");
    bus.req_valid = 4'b0000;
    step(4'b0000, "idle6");

    chk("scoreboard empty", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
